// File: rtl/jk_count_driver.sv
// Excitation controller for a bank of external JK flip-flops that together
// form a mod-MOD up/down counter with load, hold and post-reset clear.
//
// Ports:
//   clk, rst          clock shared with the FF bank; sync active-high reset
//   start, stop       pulses moving IDLE->RUN and RUN->IDLE (stop wins)
//   en, up            step enable in RUN and count direction (1 = up)
//   load, load_val    load load_val into the bank this cycle (top priority)
//   q                 feedback from the FF bank Q outputs
//   j, k              J/K excitation driven to the FF bank
//   tc                a wrapping step is being driven this cycle
//   running           controller is in RUN
//   err               sticky: bank disagreed with expectation or bad load
module jk_count_driver #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             tc,
    output logic             running,
    output logic             err
);

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    // One extra bit so MOD == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] TOP   = WIDTH'(MOD - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] nxt_up;
    logic [WIDTH-1:0] nxt_dn;
    logic             q_ovr;
    logic             lv_bad;
    logic             step_go;
    logic             q_zero;
    logic             q_top;

    // Candidate targets; an out-of-range q is folded back into range
    // so nothing outside 0..MOD-1 is ever driven.
    always_comb begin
        q_ovr   = {1'b0, q} >= MOD_W;
        lv_bad  = {1'b0, load_val} >= MOD_W;
        q_zero  = (q == '0);
        q_top   = (q == TOP);
        step_go = (state_q == S_RUN) && en && !load;
        nxt_up  = (q_top || q_ovr) ? '0 : q + WIDTH'(1);
        nxt_dn  = (q_zero || q_ovr) ? TOP : q - WIDTH'(1);
    end

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        err_d   = err_q;
        nxt     = q;
        j       = '0;
        k       = '0;
        tc      = 1'b0;

        if (rst) begin
            // Reset aborts whatever was in flight and starts the clear.
            j = '0;
            k = '1;
        end else begin
            unique case (state_q)
                S_CLEAR: begin
                    j       = '0;
                    k       = '1;
                    exp_d   = '0;
                    state_d = S_IDLE;
                end
                S_IDLE, S_RUN: begin
                    if (q != exp_q) begin
                        err_d = 1'b1;
                    end

                    if (load) begin
                        // Set/clear form: the result is independent of q.
                        nxt = lv_bad ? '0 : load_val;
                        if (lv_bad) begin
                            err_d = 1'b1;
                        end
                        j = nxt;
                        k = ~nxt;
                    end else if (step_go) begin
                        nxt = up ? nxt_up : nxt_dn;
                        j   = q ^ nxt;
                        k   = q ^ nxt;
                        tc  = up ? q_top : q_zero;
                    end else begin
                        nxt = q;
                    end

                    exp_d = nxt;

                    if (stop) begin
                        state_d = S_IDLE;
                    end else if (start && state_q == S_IDLE) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    j       = '0;
                    k       = '1;
                    exp_d   = '0;
                    state_d = S_CLEAR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            exp_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            err_q   <= err_d;
        end
    end

    assign running = (state_q == S_RUN);
    assign err     = err_q;

endmodule
